// File: rtl/bram_ring_writer.sv
// bram_ring_writer: streams 64-bit words into a circular BRAM buffer with backpressure, stall counting and fill irq.
// Optional RING_CLEAR_ON_START_EN: zero the whole ring on every start before accepting data.
module bram_ring_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8192,
  parameter int PTR_WIDTH  = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [PTR_WIDTH-1:0]    sw_rd_ptr,
  input  logic [PTR_WIDTH:0]      threshold,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_din,
  output logic [PTR_WIDTH-1:0]    wr_ptr,
  output logic [PTR_WIDTH:0]      fill_level,
  output logic [31:0]             stall_count,
  output logic                    busy,
  output logic                    irq
);
  localparam int BSH = $clog2(DATA_WIDTH/8);
  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;
  state_t                  state_q;
  logic [PTR_WIDTH-1:0]    wr_ptr_q;
  logic [PTR_WIDTH-1:0]    fill_w;
  logic [PTR_WIDTH:0]      fill_prev_q;
  logic                    en_q;
  logic [DATA_WIDTH/8-1:0] we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic [31:0]             stall_q;
  logic                    full;
  logic                    accept;
  assign fill_w      = wr_ptr_q - sw_rd_ptr;
  assign fill_level  = {1'b0, fill_w};
  assign full        = fill_w == PTR_WIDTH'(DEPTH-1);
  assign s_ready     = (state_q == RUN) && enable && !full;
  assign accept      = s_valid && s_ready;
  // rising-edge detect against last cycle's fill, so a software drain re-arms it
  assign irq         = (threshold != '0) && (fill_prev_q < threshold) && (fill_level >= threshold);
  assign busy        = state_q != IDLE;
  assign wr_ptr      = wr_ptr_q;
  assign bram_en     = en_q;
  assign bram_we     = we_q;
  assign bram_addr   = addr_q;
  assign bram_din    = din_q;
  assign stall_count = stall_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_prev_q <= '0;
      en_q        <= 1'b0;
      we_q        <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      stall_q     <= '0;
    end else begin
      en_q        <= 1'b0;
      we_q        <= '0;
      fill_prev_q <= fill_level;
      if (state_q == RUN && enable && full && s_valid && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      case (state_q)
        IDLE: if (enable) begin
`ifdef RING_CLEAR_ON_START_EN
          state_q  <= CLEAR;
          wr_ptr_q <= '0;
`else
          state_q  <= RUN;
`endif
        end
        RUN: if (!enable) state_q <= IDLE;
             else if (accept) begin
               en_q     <= 1'b1;
               we_q     <= '1;
               addr_q   <= ADDR_WIDTH'(wr_ptr_q) << BSH;
               din_q    <= s_data;
               wr_ptr_q <= wr_ptr_q + 1'b1;
             end
`ifdef RING_CLEAR_ON_START_EN
        CLEAR: if (!enable) begin
                 state_q  <= IDLE;
                 wr_ptr_q <= '0;
               end else begin
                 en_q     <= 1'b1;
                 we_q     <= '1;
                 addr_q   <= ADDR_WIDTH'(wr_ptr_q) << BSH;
                 din_q    <= '0;
                 wr_ptr_q <= wr_ptr_q + 1'b1;
                 if (wr_ptr_q == PTR_WIDTH'(DEPTH-1)) state_q <= RUN;
               end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_ring_writer.sv
// tb_bram_ring_writer: directed stimulus with a write scoreboard and a cycle-level reference model.
module tb_bram_ring_writer;
  localparam int DEPTH = 8192;
  localparam int IDLE = 0, RUN = 1, CLR = 2;
  logic        clk = 1'b0;
  logic        rst_n, enable, s_valid, s_ready, bram_en, busy, irq;
  logic [63:0] s_data, bram_din;
  logic [12:0] sw_rd_ptr, wr_ptr;
  logic [13:0] threshold, fill_level;
  logic [7:0]  bram_we;
  logic [15:0] bram_addr;
  logic [31:0] stall_count;
  typedef struct {logic [15:0] a; logic [63:0] d; int c;} exp_t;
  exp_t        q[$];
  int          ncmp = 0, nerr = 0, cyc = 0, n_irq = 0, m_st = IDLE;
  logic [12:0] m_wp = '0;
  logic [13:0] m_prev = '0;
  logic [31:0] m_stall = '0;
  logic        mon_on = 1'b0;

  bram_ring_writer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .sw_rd_ptr(sw_rd_ptr), .threshold(threshold), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .wr_ptr(wr_ptr),
    .fill_level(fill_level), .stall_count(stall_count), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string t, logic [63:0] o, logic [63:0] e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endfunction

  function automatic void push(logic [12:0] wp, logic [63:0] d);
    q.push_back('{a: {wp, 3'b000}, d: d, c: cyc + 1});
  endfunction

  // every strobe must match the oldest expected write, exactly one cycle after acceptance
  always @(negedge clk) if (mon_on) begin
    if (q.size() > 0 && q[0].c <= cyc) begin
      chk("strobe_en", bram_en, 1);
      chk("strobe_we", bram_we, 8'hFF);
      chk("strobe_addr", bram_addr, q[0].a);
      chk("strobe_data", bram_din, q[0].d);
      void'(q.pop_front());
    end else begin
      chk("no_strobe_en", bram_en, 0);
      chk("no_strobe_we", bram_we, 0);
    end
  end

  task automatic step();
    logic [12:0] f;
    logic        fl, rdy;
    @(negedge clk);
    f   = m_wp - sw_rd_ptr;
    fl  = f == 13'(DEPTH-1);
    rdy = m_st == RUN && enable && !fl;
    chk("wr_ptr", wr_ptr, m_wp);
    chk("fill_level", fill_level, {1'b0, f});
    chk("s_ready", s_ready, rdy);
    chk("busy", busy, m_st != IDLE);
    chk("irq", irq, threshold != 0 && m_prev < threshold && {1'b0, f} >= threshold);
    chk("stall_count", stall_count, m_stall);
    if (irq === 1'b1) n_irq++;
    if (!rst_n) begin
      m_wp = '0; m_st = IDLE; m_prev = '0; m_stall = '0;
    end else begin
      if (m_st == RUN && enable && fl && s_valid && m_stall != '1) m_stall++;
      m_prev = {1'b0, f};
      case (m_st)
        IDLE: if (enable) begin
`ifdef RING_CLEAR_ON_START_EN
          m_st = CLR; m_wp = '0;
`else
          m_st = RUN;
`endif
        end
        RUN: if (!enable) m_st = IDLE;
             else if (rdy && s_valid) begin push(m_wp, s_data); m_wp++; end
        default: if (!enable) begin m_st = IDLE; m_wp = '0; end
                 else begin push(m_wp, '0); if (m_wp == 13'(DEPTH-1)) m_st = RUN; m_wp++; end
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic start();
    enable = 1'b1;
    step();
`ifdef RING_CLEAR_ON_START_EN
    repeat (DEPTH) step();
    chk("clear_done_wr_ptr", wr_ptr, 0);
    chk("clear_done_busy", busy, 1);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0; sw_rd_ptr = '0; threshold = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_we", bram_we, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_bram_din", bram_din, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    mon_on = 1'b1;
    rst_n = 1'b1;
    step();
    // four beats from address zero
    start();
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin s_data = 64'hA0 + 64'(i); step(); end
    s_valid = 1'b0;
    repeat (2) step();
    chk("t1_wr_ptr", wr_ptr, 4);
    chk("t1_fill", fill_level, 4);
    // walk to 8190 with software keeping pace, then wrap
    s_valid = 1'b1;
    while (m_wp != 13'd8190) begin sw_rd_ptr = m_wp; s_data = {32'hB000_0000, 19'd0, m_wp}; step(); end
    sw_rd_ptr = 13'd8190;
    for (int i = 0; i < 3; i++) begin s_data = 64'hC0 + 64'(i); step(); end
    chk("wrap_wr_ptr", wr_ptr, 1);
    // reset while the last strobe is in flight and a beat is offered
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; s_valid = 1'b0;
    step();
    chk("rst_mid_wr_ptr", wr_ptr, 0);
    chk("rst_mid_en", bram_en, 0);
    // fill to capacity, then stall
    sw_rd_ptr = '0;
    start();
    s_valid = 1'b1;
    repeat (DEPTH - 1) begin s_data = {$urandom, $urandom}; step(); end
    chk("full_s_ready", s_ready, 0);
    chk("full_fill", fill_level, DEPTH - 1);
    repeat (10) step();
    chk("stall_10", stall_count, 10);
    sw_rd_ptr = 13'd1;
    #1;
    chk("unfull_s_ready", s_ready, 1);
    s_data = 64'hD00D;
    step();
    s_valid = 1'b0;
    step();
    // threshold interrupt, then re-arm by draining
    do_reset();
    sw_rd_ptr = '0;
    start();
    threshold = 14'd16;
    n_irq = 0;
    s_valid = 1'b1;
    repeat (20) begin s_data = {$urandom, $urandom}; step(); end
    s_valid = 1'b0;
    step();
    chk("irq_first", n_irq, 1);
    sw_rd_ptr = 13'd10;
    step();
    chk("irq_drain_fill", fill_level, 10);
    s_valid = 1'b1;
    repeat (6) begin s_data = {$urandom, $urandom}; step(); end
    s_valid = 1'b0;
    step();
    chk("irq_second", n_irq, 2);
    // enable drop mid-stream, then restart
    threshold = '0;
    do_reset();
    sw_rd_ptr = '0;
    start();
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin s_data = 64'hE0 + 64'(i); step(); end
    enable = 1'b0;
    s_data = 64'hE5;
    step();
    chk("drop_busy", busy, 0);
    chk("drop_wr_ptr", wr_ptr, 5);
    step();
    start();
    s_data = 64'hE6;
    step();
    chk("restart_en", bram_en, 1);
`ifdef RING_CLEAR_ON_START_EN
    chk("restart_addr", bram_addr, 16'h0000);
`else
    chk("restart_addr", bram_addr, 16'h0028);
`endif
    chk("restart_data", bram_din, 64'hE6);
    s_valid = 1'b0;
    repeat (2) step();
    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/bram_ring_writer.md
Name: bram_ring_writer

Overview:
- Write-side controller for the 64-bit simple dual-port BRAM that the data generator fills and the AXI BRAM controller reads.
- Accepts a valid/ready stream of 64-bit words and writes them into the BRAM as a circular buffer, wrapping at DEPTH.
- Tracks the fill level against a software-supplied read pointer, applies backpressure when the buffer is full, and raises a threshold interrupt for the PS.

Parameters:
- ADDR_WIDTH, 16, BRAM byte-address width on port A
- DATA_WIDTH, 64, word width; the BRAM write-enable is DATA_WIDTH/8 bits
- DEPTH, 8192, buffer depth in words; must be a power of two, with DEPTH*DATA_WIDTH/8 = 2^ADDR_WIDTH
- PTR_WIDTH, 13, log2(DEPTH)

Ports:
- clk  in  1  single clock; also drives BRAM port A clock
- rst_n  in  1  synchronous reset, active-low
- enable  in  1  run request from the control register
- s_data  in  DATA_WIDTH  stream data
- s_valid  in  1  stream valid
- s_ready  out  1  stream ready
- sw_rd_ptr  in  PTR_WIDTH  word index of the next word software will read
- threshold  in  PTR_WIDTH+1  fill level that triggers irq
- bram_en  out  1  port A enable
- bram_we  out  DATA_WIDTH/8  port A byte write enables
- bram_addr  out  ADDR_WIDTH  port A byte address
- bram_din  out  DATA_WIDTH  port A write data
- wr_ptr  out  PTR_WIDTH  word index of the next write
- fill_level  out  PTR_WIDTH+1  words written but not yet consumed
- stall_count  out  32  cycles with s_valid=1 while s_ready=0 because the buffer is full
- busy  out  1  state != IDLE
- irq  out  1  one-cycle pulse

Behaviour:
- Reset values (rst_n=0 at a clk edge): state=IDLE; wr_ptr=0; bram_en=0; bram_we=0; bram_addr=0; bram_din=0; stall_count=0; irq=0; busy=0.
- fill_level = (wr_ptr - sw_rd_ptr) mod DEPTH. Combinational from the registered wr_ptr.
- Usable capacity is DEPTH-1 words; full when fill_level == DEPTH-1.
- States:
  - IDLE -> RUN when enable=1 (or IDLE -> CLEAR when the optional feature is compiled in).
  - RUN -> IDLE when enable=0.
- s_ready = (state==RUN) && enable && !full. Purely combinational; it does not depend on s_valid.
- Accepted beat (s_valid && s_ready at edge N):
  - On the same edge, register bram_en=1, bram_we=all ones, bram_addr = wr_ptr<<3 (byte address), bram_din = s_data.
  - On the same edge, wr_ptr <= wr_ptr+1 mod DEPTH.
  - Write latency is 1 cycle from acceptance to the BRAM strobe.
  - Back-to-back beats sustain 1 word/cycle.
- No accepted beat: bram_en=0 and bram_we=0 on the next cycle; bram_addr and bram_din hold their values.
- Wrap: after word DEPTH-1 (byte address 0xFFF8), the next write goes to word 0 (byte address 0x0000).
- stall_count increments when state==RUN && enable && full && s_valid. It saturates at 0xFFFFFFFF and clears only on reset.
- irq pulses high for exactly one cycle when fill_level goes from < threshold to >= threshold on consecutive cycles.
  - Compare against a registered previous fill_level.
  - threshold=0 never fires.
  - A drop in fill_level caused by software re-arms irq.
- sw_rd_ptr may change on any cycle. A software read and a write in the same cycle are both reflected in the next fill_level. The block never moves sw_rd_ptr.
- enable falling mid-stream: s_ready drops combinationally in the same cycle, so no beat is accepted. A write already registered completes. wr_ptr is retained across IDLE, and a restart continues from wr_ptr.
- Reset mid-operation: an in-flight write strobe is abandoned (bram_en=0 next cycle) and wr_ptr returns to 0.

Optional Feature:
- RING_CLEAR_ON_START_EN
- Defined:
  - IDLE -> CLEAR on enable=1.
  - CLEAR writes zeros to words 0..DEPTH-1, one per cycle (bram_en=1, we all ones, din=0), taking DEPTH cycles.
  - Then wr_ptr=0 and the state goes to RUN; s_ready=0 and busy=1 throughout CLEAR.
  - enable=0 during CLEAR aborts to IDLE with wr_ptr=0.
- Undefined: there is no CLEAR state, and IDLE goes directly to RUN.

Test Plan:
- Reset, then enable=1 with sw_rd_ptr=0 and 4 beats 0xA0..0xA3 -> strobes at byte addresses 0x0000, 0x0008, 0x0010, 0x0018 with matching data, each one cycle after acceptance; wr_ptr=4; fill_level=4.
- Set wr_ptr to 8190 by streaming, with sw_rd_ptr tracking it, then send 3 beats -> addresses 0xFFF0, 0xFFF8, 0x0000; wr_ptr=1.
- sw_rd_ptr=0, stream continuously -> after 8191 accepts s_ready=0 and fill_level=8191; 10 further s_valid cycles give stall_count=10; setting sw_rd_ptr=1 restores s_ready on the same cycle.
- threshold=16, stream 20 beats -> irq high exactly one cycle, at the cycle fill_level becomes 16; advance sw_rd_ptr to drop the fill to 10, stream 6 more -> a second pulse.
- enable=0 while s_valid=1 after 5 beats -> no 6th write, busy=0 next cycle; re-enable -> next address is 0x0028.
- RING_CLEAR_ON_START_EN defined: enable=1 -> 8192 zero writes at addresses 0x0000..0xFFF8, s_ready=0 throughout, then RUN with wr_ptr=0.
